// File: rtl/regfile_pkg.sv
// Shared regfile types and default geometry, used by the regfile and its write queue.
package regfile_pkg;

    localparam int DEF_N_ENTRIES   = 32;
    localparam int DEF_ENTRY_WIDTH = 32;
    localparam int DEF_PTR_WIDTH   = $clog2(DEF_N_ENTRIES);

    typedef struct packed {
        logic [DEF_PTR_WIDTH-1:0]   addr;
        logic [DEF_ENTRY_WIDTH-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/wr_conflict_sel.sv
// Per-port write-enable selection: in-order drain from the queue head, stopping at
// the first entry that is absent or whose address collides with an earlier port.
module wr_conflict_sel #(
    parameter int N_WRITE_PORTS = 2,
    parameter int PTR_WIDTH     = 5,
    parameter int CNT_WIDTH     = 4
) (
    input  logic                               stall,
    input  logic [CNT_WIDTH-1:0]               count,
    input  logic [N_WRITE_PORTS*PTR_WIDTH-1:0] cand_addr,
    output logic [N_WRITE_PORTS-1:0]           wr_en
);

    always_comb begin
        logic chain;
        chain = !stall;
        wr_en = '0;
        for (int unsigned k = 0; k < N_WRITE_PORTS; k++) begin
            // once the chain breaks, every later port stays disabled
            if (count <= CNT_WIDTH'(k))
                chain = 1'b0;
            for (int unsigned j = 0; j < k; j++) begin
                if (cand_addr[j*PTR_WIDTH +: PTR_WIDTH] == cand_addr[k*PTR_WIDTH +: PTR_WIDTH])
                    chain = 1'b0;
            end
            wr_en[k] = chain;
        end
    end

endmodule

// File: rtl/regfile_wr_queue.sv
// Circular write queue feeding a multi-port regfile; define REGFILE_WR_QUEUE_BYPASS_EN
// to add a read-bypass lookup of the youngest pending write to a register.
module regfile_wr_queue
    import regfile_pkg::*;
#(
    parameter int N_ENTRIES     = DEF_N_ENTRIES,
    parameter int ENTRY_WIDTH   = DEF_ENTRY_WIDTH,
    parameter int N_WRITE_PORTS = 2,
    parameter int Q_DEPTH       = 8,
    localparam int PTR_WIDTH    = $clog2(N_ENTRIES),
    localparam int CNT_WIDTH    = $clog2(Q_DEPTH) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst_aL,
    input  logic                                 enq_valid,
    output logic                                 enq_ready,
    input  logic [PTR_WIDTH-1:0]                 enq_addr,
    input  logic [ENTRY_WIDTH-1:0]               enq_data,
    input  logic                                 stall,
    output logic [N_WRITE_PORTS-1:0]             wr_en,
    output logic [N_WRITE_PORTS*PTR_WIDTH-1:0]   wr_addr,
    output logic [N_WRITE_PORTS*ENTRY_WIDTH-1:0] wr_data,
    output logic [CNT_WIDTH-1:0]                 count
`ifdef REGFILE_WR_QUEUE_BYPASS_EN
    ,
    input  logic [PTR_WIDTH-1:0]                 byp_rd_addr,
    output logic                                 byp_hit,
    output logic [ENTRY_WIDTH-1:0]               byp_data
`endif
);

    localparam int QP_WIDTH = $clog2(Q_DEPTH);

    logic [PTR_WIDTH-1:0]   q_addr [Q_DEPTH];
    logic [ENTRY_WIDTH-1:0] q_data [Q_DEPTH];
    logic [QP_WIDTH-1:0]    head, tail;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   deq_n;
    logic                   enq_fire;

    logic [N_WRITE_PORTS*PTR_WIDTH-1:0]   cand_addr;
    logic [N_WRITE_PORTS*ENTRY_WIDTH-1:0] cand_data;

    assign count     = cnt_q;
    assign enq_ready = (cnt_q != CNT_WIDTH'(Q_DEPTH));
    // x0 writes are acknowledged but never allocated
    assign enq_fire  = rst_aL && enq_valid && enq_ready && (enq_addr != '0);

    always_comb begin
        logic [QP_WIDTH-1:0] idx;
        idx       = '0;
        cand_addr = '0;
        cand_data = '0;
        for (int unsigned k = 0; k < N_WRITE_PORTS; k++) begin
            idx = head + QP_WIDTH'(k);
            cand_addr[k*PTR_WIDTH +: PTR_WIDTH]     = q_addr[idx];
            cand_data[k*ENTRY_WIDTH +: ENTRY_WIDTH] = q_data[idx];
        end
    end

    wr_conflict_sel #(
        .N_WRITE_PORTS (N_WRITE_PORTS),
        .PTR_WIDTH     (PTR_WIDTH),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_sel (
        .stall     (stall),
        .count     (cnt_q),
        .cand_addr (cand_addr),
        .wr_en     (wr_en)
    );

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        deq_n   = '0;
        for (int unsigned k = 0; k < N_WRITE_PORTS; k++) begin
            if (wr_en[k]) begin
                wr_addr[k*PTR_WIDTH +: PTR_WIDTH]     = cand_addr[k*PTR_WIDTH +: PTR_WIDTH];
                wr_data[k*ENTRY_WIDTH +: ENTRY_WIDTH] = cand_data[k*ENTRY_WIDTH +: ENTRY_WIDTH];
            end
            deq_n = deq_n + CNT_WIDTH'(wr_en[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            head  <= '0;
            tail  <= '0;
            cnt_q <= '0;
        end else begin
            if (enq_fire)
                tail <= tail + QP_WIDTH'(1);
            head  <= head + QP_WIDTH'(deq_n);
            cnt_q <= cnt_q + CNT_WIDTH'(enq_fire) - deq_n;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            q_addr[tail] <= enq_addr;
            q_data[tail] <= enq_data;
        end
    end

`ifdef REGFILE_WR_QUEUE_BYPASS_EN
    // scan oldest to youngest so the last match wins
    always_comb begin
        logic [QP_WIDTH-1:0] bidx;
        bidx     = '0;
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int unsigned i = 0; i < Q_DEPTH; i++) begin
            bidx = head + QP_WIDTH'(i);
            if ((CNT_WIDTH'(i) < cnt_q) && (byp_rd_addr != '0) && (q_addr[bidx] == byp_rd_addr)) begin
                byp_hit  = 1'b1;
                byp_data = q_data[bidx];
            end
        end
    end
`endif

endmodule
